// File: rtl/mmcm_drp_pkg.sv
// Shared DRP widths, FSM state type and the valid-address map.
// The address map is used only when MMCM_DRP_ADDR_CHECK_EN is defined.
package mmcm_drp_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;
  localparam int DRP_DEPTH  = 128;

  localparam logic [DRP_ADDR_W-1:0] VALID_LO_A   = 7'h06;
  localparam logic [DRP_ADDR_W-1:0] VALID_HI_A   = 7'h16;
  localparam logic [DRP_ADDR_W-1:0] VALID_LO_B   = 7'h18;
  localparam logic [DRP_ADDR_W-1:0] VALID_HI_B   = 7'h1A;
  localparam logic [DRP_ADDR_W-1:0] VALID_POWER  = 7'h28;
  localparam logic [DRP_ADDR_W-1:0] VALID_FILT_0 = 7'h4E;
  localparam logic [DRP_ADDR_W-1:0] VALID_FILT_1 = 7'h4F;

  typedef enum logic {
    IDLE,
    WAIT
  } drp_state_e;

  function automatic logic addr_valid(input logic [DRP_ADDR_W-1:0] a);
    return ((a >= VALID_LO_A) && (a <= VALID_HI_A)) ||
           ((a >= VALID_LO_B) && (a <= VALID_HI_B)) ||
           (a == VALID_POWER) || (a == VALID_FILT_0) || (a == VALID_FILT_1);
  endfunction

endpackage

// File: rtl/mmcm_lock_model.sv
// Behavioural MMCM lock: LOCKED rises LOCK_DELAY dclk cycles after RST falls.
module mmcm_lock_model #(
  parameter int LOCK_DELAY = 64
) (
  input  logic dclk,
  input  logic rst,
  input  logic rst_mmcm,
  output logic locked
);

  logic [9:0] lock_cnt;

  // Any cycle in reset reloads the full count, so a short pulse restarts it.
  always_ff @(posedge dclk) begin
    if (rst || rst_mmcm) begin
      lock_cnt <= 10'(LOCK_DELAY);
      locked   <= 1'b0;
    end else if (lock_cnt > 10'd1) begin
      lock_cnt <= lock_cnt - 10'd1;
    end else begin
      lock_cnt <= 10'd0;
      locked   <= 1'b1;
    end
  end

endmodule

// File: rtl/mmcm_drp_responder.sv
// MMCM DRP slave model: 128x16 register file, fixed drdy latency, lock model.
// Define MMCM_DRP_ADDR_CHECK_EN to reject accesses outside the MMCM register map.
module mmcm_drp_responder
  import mmcm_drp_pkg::*;
#(
  parameter int DRDY_LATENCY = 4,
  parameter int LOCK_DELAY   = 64
) (
  input  logic                  dclk,
  input  logic                  rst,
  input  logic                  den,
  input  logic                  dwe,
  input  logic [DRP_ADDR_W-1:0] daddr,
  input  logic [DRP_DATA_W-1:0] din,
  output logic [DRP_DATA_W-1:0] dout,
  output logic                  drdy,
  input  logic                  rst_mmcm,
  output logic                  locked,
  output logic                  busy,
  output logic                  err
);

  drp_state_e            state, state_nxt;
  logic [3:0]            lat_cnt, lat_cnt_nxt;
  logic [DRP_DATA_W-1:0] mem [DRP_DEPTH];
  logic [DRP_DATA_W-1:0] rdata;
  logic                  err_q;
  logic                  accept;
  logic                  stray;
  logic                  addr_ok;

`ifdef MMCM_DRP_ADDR_CHECK_EN
  assign addr_ok = addr_valid(daddr);
`else
  assign addr_ok = 1'b1;
`endif

  always_ff @(posedge dclk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  // The drdy cycle behaves as idle so a new den there is accepted back-to-back.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    drdy        = (state == WAIT) && (lat_cnt == 4'd0);
    accept      = den && ((state == IDLE) || drdy);
    stray       = den && (state == WAIT) && !drdy;
    busy        = (state == WAIT) && !drdy;
    if (accept) begin
      state_nxt   = WAIT;
      lat_cnt_nxt = 4'(DRDY_LATENCY - 1);
    end else if (state == WAIT) begin
      if (drdy) state_nxt = IDLE;
      else      lat_cnt_nxt = lat_cnt - 4'd1;
    end
  end

  // Register file, read capture and the err pulse, which follows the offending edge.
  always_ff @(posedge dclk) begin
    if (rst) begin
      rdata <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DRP_DEPTH; i++) mem[i] <= '0;
    end else begin
      err_q <= stray || (accept && dwe && !rst_mmcm) || (accept && !addr_ok);
      if (accept) begin
        rdata <= (!dwe && addr_ok) ? mem[daddr] : '0;
        if (dwe && addr_ok) mem[daddr] <= din;
      end
    end
  end

  assign dout = drdy ? rdata : '0;
  assign err  = err_q;

  mmcm_lock_model #(
    .LOCK_DELAY(LOCK_DELAY)
  ) u_lock (
    .dclk    (dclk),
    .rst     (rst),
    .rst_mmcm(rst_mmcm),
    .locked  (locked)
  );

endmodule

// File: tb/tb_mmcm_drp_responder.sv
// Bench for mmcm_drp_responder: directed scenarios plus random traffic against a
// cycle-stamped reference model of the DRP protocol and the lock timing.
module tb_mmcm_drp_responder;

  localparam int LAT = 4;
  localparam int LD  = 64;

  logic        dclk = 1'b0;
  logic        rst = 1'b1;
  logic        den = 1'b0;
  logic        dwe = 1'b0;
  logic [6:0]  daddr = '0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        drdy;
  logic        rst_mmcm = 1'b1;
  logic        locked;
  logic        busy;
  logic        err;

  mmcm_drp_responder #(
    .DRDY_LATENCY(LAT),
    .LOCK_DELAY  (LD)
  ) dut (
    .dclk    (dclk),
    .rst     (rst),
    .den     (den),
    .dwe     (dwe),
    .daddr   (daddr),
    .din     (din),
    .dout    (dout),
    .drdy    (drdy),
    .rst_mmcm(rst_mmcm),
    .locked  (locked),
    .busy    (busy),
    .err     (err)
  );

  always #5 dclk = ~dclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: transactions are timestamped by cycle number.
  logic [15:0] m_mem [128];
  bit          m_pend = 0;
  int          m_drdy_at = 0;
  logic [15:0] m_rdata = '0;
  bit          m_err = 0;
  int          m_lock_run = 0;
  int          cyc = 0;
  logic        r_lvl = 1'b1;
  logic        rm_lvl = 1'b1;

  function automatic bit m_valid(input logic [6:0] a);
`ifdef MMCM_DRP_ADDR_CHECK_EN
    int v = int'(a);
    return (v >= 6 && v <= 22) || (v >= 24 && v <= 26) || v == 40 || v == 78 || v == 79;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_edge(input logic r, input logic rm, input logic d, input logic w,
                            input logic [6:0] a, input logic [15:0] di);
    bit drdy_now;
    drdy_now = m_pend && (m_drdy_at == cyc);
    if (r) begin
      m_pend = 0;
      m_err  = 0;
      m_rdata = '0;
      for (int i = 0; i < 128; i++) m_mem[i] = '0;
    end else begin
      m_err = 0;
      if (d && (!m_pend || drdy_now)) begin
        m_pend    = 1;
        m_drdy_at = cyc + LAT;
        m_rdata   = (!w && m_valid(a)) ? m_mem[a] : 16'h0000;
        if (w && m_valid(a)) m_mem[a] = di;
        if (w && !rm) m_err = 1;
        if (!m_valid(a)) m_err = 1;
      end else begin
        if (d) m_err = 1;
        if (drdy_now) m_pend = 0;
      end
    end
    if (r || rm) m_lock_run = 0;
    else if (m_lock_run < LD) m_lock_run++;
    cyc++;
  endtask

  task automatic check_outputs();
    bit e_drdy;
    e_drdy = m_pend && (m_drdy_at == cyc);
    chk("drdy", drdy, e_drdy);
    chk("dout", dout, e_drdy ? m_rdata : 16'h0000);
    chk("busy", busy, m_pend && !e_drdy);
    chk("err", err, m_err);
    chk("locked", locked, m_lock_run >= LD);
  endtask

  // One clock: drive inputs, let the edge happen, then compare at the falling edge.
  task automatic step(input logic d, input logic w, input logic [6:0] a, input logic [15:0] di);
    rst = r_lvl; rst_mmcm = rm_lvl; den = d; dwe = w; daddr = a; din = di;
    @(posedge dclk);
    model_edge(r_lvl, rm_lvl, d, w, a, di);
    @(negedge dclk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'h00, 16'h0000);
  endtask

  logic [6:0]  ra;
  logic [15:0] rd;

  initial begin
    for (int i = 0; i < 128; i++) m_mem[i] = '0;
    @(negedge dclk);
    idle(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_locked", locked, 1'b0);
    r_lvl = 1'b0;

    // Write then read back-to-back, den in each drdy cycle.
    step(1'b1, 1'b1, 7'h08, 16'h1145);
    idle(2);
    chk("wr_not_yet", drdy, 1'b0);
    idle(1);
    chk("wr_drdy", drdy, 1'b1);
    step(1'b1, 1'b0, 7'h08, 16'h0000);
    chk("b2b_busy", busy, 1'b1);
    idle(3);
    chk("rd_drdy", drdy, 1'b1);
    chk("rd_dout", dout, 16'h1145);

    // Stray den two cycles after accept.
    step(1'b1, 1'b0, 7'h08, 16'h0000);
    idle(1);
    step(1'b1, 1'b1, 7'h08, 16'hDEAD);
    chk("stray_err", err, 1'b1);
    idle(1);
    chk("stray_drdy", drdy, 1'b1);
    chk("stray_err_once", err, 1'b0);
    chk("stray_dout", dout, 16'h1145);

    // Lock timing with a restart pulse.
    rm_lvl = 1'b0;
    idle(30);
    rm_lvl = 1'b1;
    idle(1);
    rm_lvl = 1'b0;
    idle(63);
    chk("lock_early", locked, 1'b0);
    idle(1);
    chk("lock_on", locked, 1'b1);

    // Write while rst_mmcm is low.
    step(1'b1, 1'b1, 7'h14, 16'h00C3);
    chk("unlk_err", err, 1'b1);
    idle(3);
    step(1'b1, 1'b0, 7'h14, 16'h0000);
    idle(3);
    chk("unlk_rd", dout, 16'h00C3);

    // Address outside the MMCM map.
    step(1'b1, 1'b1, 7'h30, 16'hFFFF);
    idle(3);
    step(1'b1, 1'b0, 7'h30, 16'h0000);
    idle(3);
`ifdef MMCM_DRP_ADDR_CHECK_EN
    chk("addr30_rd", dout, 16'h0000);
`else
    chk("addr30_rd", dout, 16'hFFFF);
`endif

    // Reset in the middle of a read.
    step(1'b1, 1'b0, 7'h08, 16'h0000);
    idle(1);
    r_lvl = 1'b1;
    idle(1);
    r_lvl = 1'b0;
    idle(5);
    step(1'b1, 1'b0, 7'h08, 16'h0000);
    idle(3);
    chk("rst_rd_drdy", drdy, 1'b1);
    chk("rst_rd_dout", dout, 16'h0000);
    chk("rst_locked0", locked, 1'b0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      r_lvl = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) rm_lvl = ~rm_lvl;
      ra = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(6, 26)) : 7'($urandom_range(0, 127));
      rd = 16'($urandom);
      step(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)), ra, rd);
    end
    r_lvl = 1'b0;
    idle(LAT + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
